// File: rtl/aes_key_schedule_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule.
// The S-box table and InvMixColumns live here so every user sees one definition.
package aes_key_schedule_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    INVMIX = 2'd2,
    DONE   = 2'd3
  } aes_state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier operands are constants at every call site, so this folds to XOR trees.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] w);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      r[32*(3-c) +: 32] = inv_mix_column(w[32*(3-c) +: 32]);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Round-key interface between the key loader and the key schedule.
// master = key loader / round pipeline side, slave = key schedule.
interface aes_key_schedule_if
  import aes_key_schedule_pkg::*;
#(
  parameter int NR = AES_NR
) ();

  logic                     key_valid;
  logic [127:0]             key;
  logic                     key_ready;
  logic                     keys_valid;
  logic                     busy;
  logic [128*(NR+1)-1:0]    rk_enc;
  logic [128*(NR+1)-1:0]    rk_dec;

  modport master (
    output key_valid, key,
    input  key_ready, keys_valid, busy, rk_enc, rk_dec
  );

  modport slave (
    input  key_valid, key,
    output key_ready, keys_valid, busy, rk_enc, rk_dec
  );

endinterface

// File: rtl/aes_key_schedule_step.sv
// One AES-128 key-expansion step: next round key from the previous one and rcon.
// Purely combinational, four S-box lookups on the rotated last word.
module aes_key_schedule_step
  import aes_key_schedule_pkg::*;
(
  input  logic [127:0] w,
  input  logic [7:0]   rcon,
  output logic [127:0] w_next
);

  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [31:0] t_s;
  logic [31:0] w0_s, w1_s, w2_s, w3_s;

  assign rot_s = {w[23:0], w[31:24]};
  assign sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
  assign t_s   = sub_s ^ {rcon, 24'h000000};

  assign w0_s   = w[127:96] ^ t_s;
  assign w1_s   = w[95:64]  ^ w0_s;
  assign w2_s   = w[63:32]  ^ w1_s;
  assign w3_s   = w[31:0]   ^ w2_s;
  assign w_next = {w0_s, w1_s, w2_s, w3_s};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key schedule producing encrypt and equivalent-inverse decrypt banks.
// One encrypt key per cycle, then one InvMixColumns'd decrypt key per cycle through a shared unit.
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_key_schedule_if.slave  kif
);

  localparam logic [3:0] CNT_ENC_LAST = 4'(NR);
  localparam logic [3:0] CNT_DEC_LAST = 4'(NR - 1);

  aes_state_t   state_r, state_next_s;
  logic [3:0]   cnt_r, cnt_next_s;
  logic         keys_valid_r, keys_valid_next_s;
  logic         key_ready_r;
  logic         busy_r;
  logic         accept_s, exp_we_s, exp_last_s, inv_we_s;
  logic [127:0] enc_bank_r [NR+1];
  logic [127:0] dec_bank_r [NR+1];
  logic [127:0] step_in_s, step_out_s;
  logic [127:0] imix_in_s, imix_out_s;
  logic [7:0]   rcon_s;

  // Next-state and bank write strobes; any out-of-range counter falls back to IDLE.
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    keys_valid_next_s = keys_valid_r;
    accept_s          = 1'b0;
    exp_we_s          = 1'b0;
    exp_last_s        = 1'b0;
    inv_we_s          = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (kif.key_valid) begin
          accept_s          = 1'b1;
          state_next_s      = EXPAND;
          cnt_next_s        = 4'd1;
          keys_valid_next_s = 1'b0;
        end else begin
          state_next_s = state_r;
        end
      end
      EXPAND: begin
        if ((cnt_r == 4'd0) || (cnt_r > CNT_ENC_LAST)) begin
          state_next_s      = IDLE;
          cnt_next_s        = 4'd0;
          keys_valid_next_s = 1'b0;
        end else if (cnt_r == CNT_ENC_LAST) begin
          exp_we_s     = 1'b1;
          exp_last_s   = 1'b1;
          state_next_s = INVMIX;
          cnt_next_s   = 4'd1;
        end else begin
          exp_we_s   = 1'b1;
          cnt_next_s = cnt_r + 4'd1;
        end
      end
      INVMIX: begin
        if ((cnt_r == 4'd0) || (cnt_r > CNT_DEC_LAST)) begin
          state_next_s      = IDLE;
          cnt_next_s        = 4'd0;
          keys_valid_next_s = 1'b0;
        end else if (cnt_r == CNT_DEC_LAST) begin
          inv_we_s          = 1'b1;
          state_next_s      = DONE;
          cnt_next_s        = 4'd0;
          keys_valid_next_s = 1'b1;
        end else begin
          inv_we_s   = 1'b1;
          cnt_next_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_next_s      = IDLE;
        cnt_next_s        = 4'd0;
        keys_valid_next_s = 1'b0;
      end
    endcase
  end

  // State, counter and status outputs; status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      keys_valid_r <= 1'b0;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      keys_valid_r <= keys_valid_next_s;
      key_ready_r  <= (state_next_s == IDLE) || (state_next_s == DONE);
      busy_r       <= (state_next_s == EXPAND) || (state_next_s == INVMIX);
    end
  end

  // Source selection: previous encrypt key for the step, mirrored key for InvMixColumns.
  always_comb begin
    step_in_s = 128'h0;
    imix_in_s = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      step_in_s = (cnt_r == 4'(i + 1)) ? enc_bank_r[i] : step_in_s;
      imix_in_s = (cnt_r == 4'(NR - i)) ? enc_bank_r[i] : imix_in_s;
    end
  end

  assign rcon_s     = rcon_lut(cnt_r);
  assign imix_out_s = inv_mix_columns(imix_in_s);

  aes_key_schedule_step u_step (
    .w      (step_in_s),
    .rcon   (rcon_s),
    .w_next (step_out_s)
  );

  // Key banks; the last expand edge also seeds both ends of the decrypt bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) begin
        enc_bank_r[i] <= 128'h0;
        dec_bank_r[i] <= 128'h0;
      end
    end else begin
      if (accept_s) begin
        enc_bank_r[0] <= kif.key;
      end
      for (int i = 1; i <= NR; i++) begin
        if (exp_we_s && (cnt_r == 4'(i))) begin
          enc_bank_r[i] <= step_out_s;
        end
      end
      if (exp_last_s) begin
        dec_bank_r[0]  <= step_out_s;
        dec_bank_r[NR] <= enc_bank_r[0];
      end
      for (int i = 1; i < NR; i++) begin
        if (inv_we_s && (cnt_r == 4'(i))) begin
          dec_bank_r[i] <= imix_out_s;
        end
      end
    end
  end

  // Flatten the banks onto the interface straight from registers.
  always_comb begin
    kif.rk_enc = '0;
    kif.rk_dec = '0;
    for (int i = 0; i <= NR; i++) begin
      kif.rk_enc[128*i +: 128] = enc_bank_r[i];
      kif.rk_dec[128*i +: 128] = dec_bank_r[i];
    end
  end

  assign kif.key_ready  = key_ready_r;
  assign kif.keys_valid = keys_valid_r;
  assign kif.busy       = busy_r;

endmodule
